// File: rtl/spi_target.sv
// SPI mode-0 target: synchronised SCK/CS/MOSI, byte RX pulse, one-entry TX holding register.
// Optional saturating error counter enabled by defining SPI_TARGET_ERR_CNT_EN.
module spi_target #(
  parameter int unsigned SyncStages = 2,
  parameter logic [7:0]  TxIdleByte = 8'hFF
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_sdi_i,
  output logic       spi_sdo_o,
  output logic       spi_sdo_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       tx_underrun_o,
  output logic [7:0] err_cnt_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [SyncStages-1:0] sck_sync;
  logic [SyncStages-1:0] cs_sync;
  logic [SyncStages-1:0] sdi_sync;
  logic                  sck_s;
  logic                  cs_s;
  logic                  sdi_s;
  logic                  sck_prev;
  logic                  cs_prev;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  cs_rise;
  logic                  cs_fall;
  logic [2:0]            bit_cnt;
  logic [6:0]            rx_shift;
  logic [7:0]            tx_shift;
  logic [7:0]            hold_data;
  logic                  hold_empty;
  logic                  load;
  logic                  from_hold;
  logic                  accept;
  logic                  underrun;
  logic [7:0]            tx_load;

  assign sck_s      = sck_sync[SyncStages-1];
  assign cs_s       = cs_sync[SyncStages-1];
  assign sdi_s      = sdi_sync[SyncStages-1];
  assign sck_rise   = sck_s & ~sck_prev;
  assign sck_fall   = ~sck_s & sck_prev;
  assign cs_rise    = cs_s & ~cs_prev;
  assign cs_fall    = ~cs_s & cs_prev;
  assign spi_sdo_o  = tx_shift[7];
  assign tx_ready_o = hold_empty;

  // Pin synchronisers plus previous-value flops for edge detection.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SyncStages-2:0], spi_sck_i};
      cs_sync  <= {cs_sync[SyncStages-2:0], spi_cs_ni};
      sdi_sync <= {sdi_sync[SyncStages-2:0], spi_sdi_i};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  // Shift-register load events and their data source.
  always_comb begin
    load = 1'b0;
    if (state == IDLE) begin
      load = cs_fall;
    end else begin
      load = ~cs_rise & sck_fall & (bit_cnt == 3'd0);
    end
    from_hold = load & ~hold_empty;
    underrun  = load & hold_empty;
    accept    = tx_valid_i & hold_empty;
    tx_load   = from_hold ? hold_data : TxIdleByte;
  end

  // One-entry TX holding register; a coincident accept stays buffered.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      hold_empty <= 1'b1;
      hold_data  <= 8'h00;
    end else if (from_hold) begin
      hold_empty <= 1'b1;
    end else if (accept) begin
      hold_data  <= tx_data_i;
      hold_empty <= 1'b0;
    end
  end

  // Frame FSM: CS rise wins over a same-cycle SCK edge.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx_shift      <= 7'h00;
      tx_shift      <= 8'h00;
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
      busy_o        <= 1'b0;
      spi_sdo_en_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= underrun;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state        <= SHIFT;
            busy_o       <= 1'b1;
            spi_sdo_en_o <= 1'b1;
            bit_cnt      <= 3'd0;
            tx_shift     <= tx_load;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            spi_sdo_en_o <= 1'b0;
            bit_cnt      <= 3'd0;
            tx_shift     <= 8'h00;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[5:0], sdi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_o  <= {rx_shift, sdi_s};
              rx_valid_o <= 1'b1;
            end
          end else if (sck_fall) begin
            if (bit_cnt == 3'd0) begin
              tx_shift <= tx_load;
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

`ifdef SPI_TARGET_ERR_CNT_EN
  logic       abort;
  logic [7:0] err_cnt;

  assign abort     = (state == SHIFT) & cs_rise & (bit_cnt != 3'd0);
  assign err_cnt_o = err_cnt;

  // Saturating count of underruns and mid-byte aborts.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      err_cnt <= 8'h00;
    end else if ((underrun | abort) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: expected RX/TX bytes queued at drive time.
// Error-counter expectations follow SPI_TARGET_ERR_CNT_EN.
module tb_spi_target;

`ifdef SPI_TARGET_ERR_CNT_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo;
  logic       sdo_en;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       underrun;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int ur_cnt = 0;
  int exp_err = 0;
  logic [7:0] rx_obs[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  spi_target dut (
    .clk_sys_i    (clk),
    .rst_sys_i    (rst),
    .spi_sck_i    (sck),
    .spi_cs_ni    (cs_n),
    .spi_sdi_i    (sdi),
    .spi_sdo_o    (sdo),
    .spi_sdo_en_o (sdo_en),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .busy_o       (busy),
    .tx_underrun_o(underrun),
    .err_cnt_o    (err_cnt)
  );

  always #5 clk = ~clk;

  // Output monitor: records RX pulses and underrun pulses.
  always @(negedge clk) begin
    if (rx_valid) rx_obs.push_back(rx_data);
    if (underrun) ur_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 50) begin
      cyc(1);
      t++;
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL offer_timeout: tx_ready=%b want 1", tx_ready);
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
      exp_tx.push_back(b);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] mosi, input bit last,
                          output logic [7:0] miso);
    for (int i = 7; i >= 0; i--) begin
      sdi = mosi[i];
      cyc(HALF);
      miso[i] = sdo;
      sck = 1'b1;
      cyc(HALF);
      if (last && i == 0) begin
        cs_n = 1'b1;
        cyc(HALF);
      end
      sck = 1'b0;
    end
    if (last) cyc(HALF);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_cmp += 4;
    if (sdo !== 1'b0 || sdo_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_sdo: sdo=%b en=%b want 0 0", sdo, sdo_en);
    end
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready: ready=%b busy=%b want 1 0", tx_ready, busy);
    end
    if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rx: data=%h valid=%b want 00 0", rx_data, rx_valid);
    end
    if (err_cnt !== 8'h00 || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_err: err=%h ur=%b want 00 0", err_cnt, underrun);
    end
    rst = 1'b0;
    cyc(HALF);
  endtask

  task automatic test_single();
    logic [7:0] miso;
    logic [7:0] got;
    logic [7:0] exp;
    int ur0;
    ur0 = ur_cnt;
    offer(8'hA5);
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL single_full: tx_ready=%b want 0", tx_ready);
    end
    exp_rx.push_back(8'h3C);
    cs_n = 1'b0;
    cyc(2);
    n_cmp++;
    if (tx_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early: ready=%b busy=%b want 0 0", tx_ready, busy);
    end
    cyc(1);
    n_cmp++;
    if (tx_ready !== 1'b1 || busy !== 1'b1 || sdo_en !== 1'b1) begin
      n_bad++;
      $display("FAIL single_load: ready=%b busy=%b en=%b want 1 1 1",
               tx_ready, busy, sdo_en);
    end
    spi_xfer(8'h3C, 1'b1, miso);
    exp = exp_tx.pop_front();
    n_cmp++;
    if (miso !== exp) begin
      n_bad++;
      $display("FAIL single_miso: got %h want %h", miso, exp);
    end
    n_cmp++;
    if (rx_obs.size() != 1) begin
      n_bad++;
      $display("FAIL single_rx_cnt: got %0d want 1", rx_obs.size());
    end else begin
      got = rx_obs.pop_front();
      exp = exp_rx.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL single_rx: got %h want %h", got, exp);
      end
    end
    n_cmp++;
    if (ur_cnt - ur0 != 0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_end: ur=%0d ready=%b busy=%b want 0 1 0",
               ur_cnt - ur0, tx_ready, busy);
    end
    rx_obs = {};
    exp_rx = {};
  endtask

  task automatic test_back_to_back();
    logic [7:0] miso[2];
    logic [7:0] mosi[2];
    logic [7:0] got;
    logic [7:0] exp;
    int ur0;
    ur0 = ur_cnt;
    mosi[0] = 8'hF0;
    mosi[1] = 8'h0F;
    offer(8'h11);
    cs_n = 1'b0;
    offer(8'h22);
    for (int b = 0; b < 2; b++) begin
      exp_rx.push_back(mosi[b]);
      spi_xfer(mosi[b], b == 1, miso[b]);
    end
    for (int b = 0; b < 2; b++) begin
      exp = exp_tx.pop_front();
      n_cmp++;
      if (miso[b] !== exp) begin
        n_bad++;
        $display("FAIL b2b_miso%0d: got %h want %h", b, miso[b], exp);
      end
    end
    n_cmp++;
    if (rx_obs.size() != 2) begin
      n_bad++;
      $display("FAIL b2b_rx_cnt: got %0d want 2", rx_obs.size());
    end else begin
      for (int b = 0; b < 2; b++) begin
        got = rx_obs.pop_front();
        exp = exp_rx.pop_front();
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL b2b_rx%0d: got %h want %h", b, got, exp);
        end
      end
    end
    n_cmp++;
    if (ur_cnt - ur0 != 0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_end: ur=%0d ready=%b want 0 1", ur_cnt - ur0, tx_ready);
    end
    rx_obs = {};
    exp_rx = {};
  endtask

  task automatic test_underrun();
    logic [7:0] miso;
    logic [7:0] exp;
    logic [7:0] exp_e;
    int ur0;
    ur0 = ur_cnt;
    exp_tx.push_back(8'hFF);
    exp_rx.push_back(8'h5A);
    cs_n = 1'b0;
    spi_xfer(8'h5A, 1'b1, miso);
    exp_err++;
    exp = exp_tx.pop_front();
    n_cmp++;
    if (miso !== exp) begin
      n_bad++;
      $display("FAIL ur_miso: got %h want %h", miso, exp);
    end
    n_cmp++;
    if (ur_cnt - ur0 != 1) begin
      n_bad++;
      $display("FAIL ur_pulses: got %0d want 1", ur_cnt - ur0);
    end
    exp_e = ErrEn ? 8'(exp_err) : 8'h00;
    n_cmp++;
    if (err_cnt !== exp_e) begin
      n_bad++;
      $display("FAIL ur_err: got %h want %h", err_cnt, exp_e);
    end
    exp = exp_rx.pop_front();
    n_cmp++;
    if (rx_obs.size() != 1 || rx_obs[0] !== exp) begin
      n_bad++;
      $display("FAIL ur_rx: cnt=%0d want 1 byte %h", rx_obs.size(), exp);
    end
    rx_obs = {};
  endtask

  task automatic test_abort();
    logic [7:0] miso;
    logic [7:0] exp;
    logic [7:0] exp_e;
    int ur0;
    ur0 = ur_cnt;
    cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sdi = 1'b1;
      cyc(HALF);
      sck = 1'b1;
      cyc(HALF);
      if (i < 4) sck = 1'b0;
    end
    cs_n = 1'b1;
    cyc(2);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_busy_early: got %b want 1", busy);
    end
    cyc(1);
    n_cmp++;
    if (busy !== 1'b0 || sdo_en !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: busy=%b en=%b want 0 0", busy, sdo_en);
    end
    sck = 1'b0;
    cyc(HALF);
    exp_err += 2;
    n_cmp++;
    if (rx_obs.size() != 0) begin
      n_bad++;
      $display("FAIL abort_rx: got %0d pulses want 0", rx_obs.size());
    end
    rx_obs = {};
    exp_tx.push_back(8'hFF);
    exp_rx.push_back(8'h81);
    cs_n = 1'b0;
    spi_xfer(8'h81, 1'b1, miso);
    exp_err++;
    exp = exp_tx.pop_front();
    n_cmp++;
    if (miso !== exp) begin
      n_bad++;
      $display("FAIL abort_next_miso: got %h want %h", miso, exp);
    end
    exp = exp_rx.pop_front();
    n_cmp++;
    if (rx_obs.size() != 1 || rx_obs[0] !== exp) begin
      n_bad++;
      $display("FAIL abort_next_rx: cnt=%0d want 1 byte %h", rx_obs.size(), exp);
    end
    rx_obs = {};
    n_cmp++;
    if (ur_cnt - ur0 != 2) begin
      n_bad++;
      $display("FAIL abort_ur: got %0d want 2", ur_cnt - ur0);
    end
    exp_e = ErrEn ? 8'(exp_err) : 8'h00;
    n_cmp++;
    if (err_cnt !== exp_e) begin
      n_bad++;
      $display("FAIL abort_err: got %h want %h", err_cnt, exp_e);
    end
  endtask

  task automatic test_mid_reset();
    offer(8'h77);
    cs_n = 1'b0;
    cyc(4);
    offer(8'h66);
    for (int i = 0; i < 3; i++) begin
      sdi = 1'b1;
      cyc(HALF);
      sck = 1'b1;
      cyc(HALF);
      sck = 1'b0;
    end
    n_cmp++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mrst_pre: ready=%b busy=%b want 0 1", tx_ready, busy);
    end
    rst  = 1'b1;
    cs_n = 1'b1;
    sdi  = 1'b0;
    cyc(1);
    n_cmp++;
    if (sdo !== 1'b0 || sdo_en !== 1'b0 || busy !== 1'b0 ||
        tx_ready !== 1'b1 || rx_data !== 8'h00 || rx_valid !== 1'b0 ||
        underrun !== 1'b0 || err_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL mrst_out: sdo=%b en=%b busy=%b rdy=%b rx=%h v=%b ur=%b err=%h want 0 0 0 1 00 0 0 00",
               sdo, sdo_en, busy, tx_ready, rx_data, rx_valid, underrun, err_cnt);
    end
    rst = 1'b0;
    exp_err = 0;
    exp_tx = {};
    cyc(HALF);
    n_cmp++;
    if (rx_obs.size() != 0) begin
      n_bad++;
      $display("FAIL mrst_rx: got %0d pulses want 0", rx_obs.size());
    end
    rx_obs = {};
  endtask

  task automatic test_saturate();
    logic [7:0] exp_e;
    int ur0;
    ur0 = ur_cnt;
    for (int i = 0; i < 300; i++) begin
      cs_n = 1'b0;
      cyc(5);
      cs_n = 1'b1;
      cyc(5);
      if (exp_err < 255) exp_err++;
      if (i == 99) begin
        exp_e = ErrEn ? 8'(exp_err) : 8'h00;
        n_cmp++;
        if (err_cnt !== exp_e) begin
          n_bad++;
          $display("FAIL sat_mid: got %h want %h", err_cnt, exp_e);
        end
      end
    end
    n_cmp++;
    if (ur_cnt - ur0 != 300) begin
      n_bad++;
      $display("FAIL sat_ur: got %0d want 300", ur_cnt - ur0);
    end
    exp_e = ErrEn ? 8'(exp_err) : 8'h00;
    n_cmp++;
    if (err_cnt !== exp_e) begin
      n_bad++;
      $display("FAIL sat_err: got %h want %h", err_cnt, exp_e);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_mid_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
